// File: rtl/hist2d_accumulator_if.sv
// hist2d_accumulator_if: the coordinate input stream and the histogram readout
// stream of hist2d_accumulator grouped into one bundle.
// The slave modport is the accumulator's view. The master modport is the view
// of whatever feeds coordinates and drains readout beats.
interface hist2d_accumulator_if #(
  parameter int COORD_W = 6,
  parameter int COUNT_W = 16
);

  logic               in_valid;
  logic [COORD_W-1:0] in_i_coord;
  logic [COORD_W-1:0] in_q_coord;

  logic               out_valid;
  logic               out_ready;
  logic [COORD_W-1:0] out_i;
  logic [COORD_W-1:0] out_q;
  logic [COUNT_W-1:0] out_count;
  logic               out_last;

  modport master (
    output in_valid, in_i_coord, in_q_coord, out_ready,
    input  out_valid, out_i, out_q, out_count, out_last
  );

  modport slave (
    input  in_valid, in_i_coord, in_q_coord, out_ready,
    output out_valid, out_i, out_q, out_count, out_last
  );

endinterface

// File: rtl/hist2d_accumulator.sv
// hist2d_accumulator: accumulates per-shot (i, q) bin coordinates into an
// on-chip count memory. On dump_req it streams every valid bin, followed by an
// overflow beat, over a valid/ready handshake. Each bin is cleared as it is
// read out.
// Optional feature: define HIST2D_ACC_SATURATE_EN so that bin counts and the
// overflow counter saturate at all-ones. When it is undefined they wrap.
module hist2d_accumulator #(
  parameter int COORD_W = 6,
  parameter int COUNT_W = 16
) (
  input  logic               clk100,
  input  logic               reset,
  hist2d_accumulator_if.slave bus,
  input  logic [COORD_W-1:0] i_bin_num,
  input  logic [COORD_W-1:0] q_bin_num,
  input  logic               dump_req,
  output logic               busy,
  output logic               drop
);

  localparam int ADDR_W = 2 * COORD_W;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam logic [COORD_W-1:0] COORD_ONE = COORD_W'(1);
  localparam logic [ADDR_W-1:0]  ADDR_ONE  = ADDR_W'(1);
  localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

  typedef enum logic [2:0] {
    CLEAR,
    ACCUM,
    DRAIN,
    DUMP_RD,
    DUMP_OUT,
    DUMP_OVF
  } state_t;

  state_t state, state_nxt;

  // Count memory: one write port and one synchronous read port.
  logic [COUNT_W-1:0] mem [DEPTH];
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [COUNT_W-1:0] mem_wdata;
  logic               mem_re;
  logic [ADDR_W-1:0]  mem_raddr;
  logic [COUNT_W-1:0] mem_rdata;

  // Clear sweep, dump cursor and the bin limits latched for this dump.
  logic [ADDR_W-1:0]  clr_addr;
  logic [COORD_W-1:0] dump_i;
  logic [COORD_W-1:0] dump_q;
  logic [COORD_W-1:0] i_lim;
  logic [COORD_W-1:0] q_lim;
  logic [COUNT_W-1:0] ovf_count;

  // Read-modify-write pipeline: stage 1 holds the sample whose read has returned.
  logic               s1_valid;
  logic [ADDR_W-1:0]  s1_addr;
  logic [COUNT_W-1:0] s1_base;
  logic [COUNT_W-1:0] s1_next;

  // The write committed on the previous edge. A read issued in that same cycle
  // could not see it yet, so it is forwarded into stage 1.
  logic               wr_valid_q;
  logic [ADDR_W-1:0]  wr_addr_q;
  logic [COUNT_W-1:0] wr_data_q;

  logic               in_range;
  logic               accept;
  logic               beat_accept;
  logic               last_i;
  logic               last_q;
  logic [ADDR_W-1:0]  in_addr;
  logic [ADDR_W-1:0]  dump_addr;

  function automatic logic [COUNT_W-1:0] bump(input logic [COUNT_W-1:0] v);
`ifdef HIST2D_ACC_SATURATE_EN
    bump = (&v) ? v : v + COUNT_ONE;
`else
    bump = v + COUNT_ONE;
`endif
  endfunction

  assign in_addr   = {bus.in_i_coord, bus.in_q_coord};
  assign dump_addr = {dump_i, dump_q};
  assign in_range  = (bus.in_i_coord < i_bin_num) && (bus.in_q_coord < q_bin_num);
  assign last_i    = (dump_i == i_lim - COORD_ONE);
  assign last_q    = (dump_q == q_lim - COORD_ONE);

  assign s1_base = (wr_valid_q && (wr_addr_q == s1_addr)) ? wr_data_q : mem_rdata;
  assign s1_next = bump(s1_base);

  assign busy = (state != ACCUM);
  assign drop = bus.in_valid && (state != ACCUM);

  assign bus.out_valid = (state == DUMP_OUT) || (state == DUMP_OVF);
  assign bus.out_last  = (state == DUMP_OVF);
  assign bus.out_i     = (state == DUMP_OUT) ? dump_i :
                         (state == DUMP_OVF) ? {COORD_W{1'b1}} : '0;
  assign bus.out_q     = (state == DUMP_OUT) ? dump_q :
                         (state == DUMP_OVF) ? {COORD_W{1'b1}} : '0;
  assign bus.out_count = (state == DUMP_OUT) ? mem_rdata :
                         (state == DUMP_OVF) ? ovf_count : '0;

  // State register; reset always restarts the full memory clear.
  always_ff @(posedge clk100) begin
    if (reset) begin
      state <= CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic plus the memory port steering for each state.
  always_comb begin
    state_nxt   = state;
    mem_we      = 1'b0;
    mem_waddr   = s1_addr;
    mem_wdata   = s1_next;
    mem_re      = 1'b0;
    mem_raddr   = in_addr;
    accept      = 1'b0;
    beat_accept = 1'b0;

    case (state)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_addr;
        mem_wdata = '0;
        if (&clr_addr) begin
          state_nxt = ACCUM;
        end
      end

      ACCUM: begin
        mem_we = s1_valid;
        if (bus.in_valid) begin
          accept = 1'b1;
          mem_re = in_range;
        end
        if (dump_req) begin
          state_nxt = DRAIN;
        end
      end

      DRAIN: begin
        mem_we = s1_valid;
        if ((i_lim == '0) || (q_lim == '0)) begin
          state_nxt = DUMP_OVF;
        end else begin
          state_nxt = DUMP_RD;
        end
      end

      DUMP_RD: begin
        mem_re    = 1'b1;
        mem_raddr = dump_addr;
        state_nxt = DUMP_OUT;
      end

      DUMP_OUT: begin
        if (bus.out_ready) begin
          beat_accept = 1'b1;
          mem_we      = 1'b1;
          mem_waddr   = dump_addr;
          mem_wdata   = '0;
          state_nxt   = (last_i && last_q) ? DUMP_OVF : DUMP_RD;
        end
      end

      DUMP_OVF: begin
        if (bus.out_ready) begin
          beat_accept = 1'b1;
          state_nxt   = ACCUM;
        end
      end

      default: begin
        state_nxt = CLEAR;
      end
    endcase
  end

  // Count memory. It has no reset because the CLEAR sweep initialises it.
  always_ff @(posedge clk100) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    if (mem_re) begin
      mem_rdata <= mem[mem_raddr];
    end
  end

  // Accumulate pipeline and last-write tracking for forwarding.
  always_ff @(posedge clk100) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_addr    <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      s1_valid   <= accept && in_range;
      s1_addr    <= in_addr;
      wr_valid_q <= mem_we;
      wr_addr_q  <= mem_waddr;
      wr_data_q  <= mem_wdata;
    end
  end

  // Clear sweep address, which advances only while clearing.
  always_ff @(posedge clk100) begin
    if (reset) begin
      clr_addr <= '0;
    end else if (state == CLEAR) begin
      clr_addr <= clr_addr + ADDR_ONE;
    end else begin
      clr_addr <= '0;
    end
  end

  // Overflow counter: out-of-range samples in ACCUM, cleared by CLEAR or by the overflow beat.
  always_ff @(posedge clk100) begin
    if (reset) begin
      ovf_count <= '0;
    end else if (state == CLEAR) begin
      ovf_count <= '0;
    end else if ((state == DUMP_OVF) && beat_accept) begin
      ovf_count <= '0;
    end else if (accept && !in_range) begin
      ovf_count <= bump(ovf_count);
    end
  end

  // Dump cursor: latch the bin limits on dump_req, then walk i outer and q inner.
  always_ff @(posedge clk100) begin
    if (reset) begin
      i_lim  <= '0;
      q_lim  <= '0;
      dump_i <= '0;
      dump_q <= '0;
    end else if ((state == ACCUM) && dump_req) begin
      i_lim  <= i_bin_num;
      q_lim  <= q_bin_num;
      dump_i <= '0;
      dump_q <= '0;
    end else if ((state == DUMP_OUT) && beat_accept) begin
      if (last_q) begin
        dump_q <= '0;
        dump_i <= dump_i + COORD_ONE;
      end else begin
        dump_q <= dump_q + COORD_ONE;
      end
    end
  end

endmodule

// File: tb/tb_hist2d_accumulator.sv
// tb_hist2d_accumulator: directed scoreboard bench for hist2d_accumulator.
// Stimulus pushes the hand-computed beats it expects. A monitor pops and
// compares them whenever a beat is accepted, and it also checks that beat
// fields hold steady while stalled.
module tb_hist2d_accumulator;

  localparam int COORD_W = 6;
  localparam int COUNT_W = 16;

  typedef struct packed {
    logic [COORD_W-1:0] i;
    logic [COORD_W-1:0] q;
    logic [COUNT_W-1:0] count;
    logic               last;
  } beat_t;

  logic               clk100;
  logic               reset;
  logic [COORD_W-1:0] i_bin_num;
  logic [COORD_W-1:0] q_bin_num;
  logic               dump_req;
  logic               busy;
  logic               drop;

  hist2d_accumulator_if #(.COORD_W(COORD_W), .COUNT_W(COUNT_W)) bus ();

  hist2d_accumulator #(.COORD_W(COORD_W), .COUNT_W(COUNT_W)) dut (
    .clk100    (clk100),
    .reset     (reset),
    .bus       (bus),
    .i_bin_num (i_bin_num),
    .q_bin_num (q_bin_num),
    .dump_req  (dump_req),
    .busy      (busy),
    .drop      (drop)
  );

  beat_t exp_q[$];
  int    n_vectors     = 0;
  int    n_miscompares = 0;
  int    ready_mode    = 0;
  int    hand [4][4];

  // 100 MHz clock
  initial begin
    clk100 = 1'b0;
    forever #5 clk100 = ~clk100;
  end

  // Readout back-pressure: 0 = always ready, 1 = toggle each cycle, 2 = held low
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk100);
      #1;
      case (ready_mode)
        1:       bus.out_ready = ~bus.out_ready;
        2:       bus.out_ready = 1'b0;
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: compare accepted beats against the scoreboard and check stall stability
  initial begin
    beat_t cur;
    beat_t held;
    beat_t e;
    bit    held_valid;
    held_valid = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk100);
      if (reset) begin
        held_valid = 1'b0;
      end else if (bus.out_valid) begin
        cur = {bus.out_i, bus.out_q, bus.out_count, bus.out_last};
        if (held_valid) begin
          n_vectors++;
          if (cur !== held) begin
            n_miscompares++;
            $display("[TB] FAIL stall_hold: got i=%0d q=%0d count=%0d last=%0d, required i=%0d q=%0d count=%0d last=%0d",
                     cur.i, cur.q, cur.count, cur.last, held.i, held.q, held.count, held.last);
          end
        end
        if (bus.out_ready) begin
          n_vectors++;
          if (exp_q.size() == 0) begin
            n_miscompares++;
            $display("[TB] FAIL unexpected_beat: got i=%0d q=%0d count=%0d last=%0d, required no beat",
                     cur.i, cur.q, cur.count, cur.last);
          end else begin
            e = exp_q.pop_front();
            if (cur !== e) begin
              n_miscompares++;
              $display("[TB] FAIL beat: got i=%0d q=%0d count=%0d last=%0d, required i=%0d q=%0d count=%0d last=%0d",
                       cur.i, cur.q, cur.count, cur.last, e.i, e.q, e.count, e.last);
            end
          end
          held_valid = 1'b0;
        end else begin
          held       = cur;
          held_valid = 1'b1;
        end
      end else begin
        held_valid = 1'b0;
      end
    end
  end

  // Watchdog
  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [COORD_W-1:0] ci, input logic [COORD_W-1:0] cq);
    bus.in_valid   = 1'b1;
    bus.in_i_coord = ci;
    bus.in_q_coord = cq;
    tick();
    bus.in_valid   = 1'b0;
  endtask

  task automatic clearHand();
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        hand[a][b] = 0;
  endtask

  task automatic expectDump(input int ni, input int nq, input int ovf);
    beat_t b;
    for (int a = 0; a < ni; a++) begin
      for (int c = 0; c < nq; c++) begin
        b.i     = COORD_W'(a);
        b.q     = COORD_W'(c);
        b.count = COUNT_W'(hand[a][c]);
        b.last  = 1'b0;
        exp_q.push_back(b);
      end
    end
    b.i     = '1;
    b.q     = '1;
    b.count = COUNT_W'(ovf);
    b.last  = 1'b1;
    exp_q.push_back(b);
  endtask

  task automatic startDump(input bit with_sample, input logic [COORD_W-1:0] si,
                           input logic [COORD_W-1:0] sq, input int lat);
    dump_req = 1'b1;
    if (with_sample) begin
      bus.in_valid   = 1'b1;
      bus.in_i_coord = si;
      bus.in_q_coord = sq;
      #1;
      checkOutput("no_drop_in_accum", drop, 0);
    end
    tick();
    dump_req     = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("busy_after_dump_req", busy, 1);
    for (int c = 1; c <= lat; c++) begin
      checkOutput("dump_latency", bus.out_valid, (c == lat));
      if (c < lat) tick();
    end
  endtask

  task automatic waitIdle(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (!busy && (exp_q.size() == 0)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    n_vectors++;
    if (!ok) begin
      n_miscompares++;
      $display("[TB] FAIL %s: timed out with %0d beats outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic waitClear(input string name);
    int n;
    n = 0;
    while (busy && (n < 5000)) begin
      tick();
      n++;
    end
    checkOutput(name, n, 4096);
  endtask

  initial begin
    reset          = 1'b1;
    dump_req       = 1'b0;
    i_bin_num      = '0;
    q_bin_num      = '0;
    bus.in_valid   = 1'b0;
    bus.in_i_coord = '0;
    bus.in_q_coord = '0;
    tick();
    tick();
    reset = 1'b0;

    $display("[TB] reset values");
    checkOutput("reset_out_valid", bus.out_valid, 0);
    checkOutput("reset_out_i", bus.out_i, 0);
    checkOutput("reset_out_q", bus.out_q, 0);
    checkOutput("reset_out_count", bus.out_count, 0);
    checkOutput("reset_out_last", bus.out_last, 0);
    checkOutput("reset_busy", busy, 1);
    checkOutput("reset_drop", drop, 0);
    waitClear("initial_clear_cycles");

    $display("[TB] empty 2x2 dump");
    i_bin_num = 6'd2;
    q_bin_num = 6'd2;
    clearHand();
    expectDump(2, 2, 0);
    startDump(1'b0, '0, '0, 3);
    waitIdle("dump_2x2_empty");

    $display("[TB] 3x3 accumulate with forwarding and overflow");
    i_bin_num = 6'd3;
    q_bin_num = 6'd3;
    applyStimulus(6'd1, 6'd2);
    applyStimulus(6'd1, 6'd2);
    applyStimulus(6'd0, 6'd0);
    applyStimulus(6'd63, 6'd5);
    clearHand();
    hand[0][0] = 1;
    hand[1][2] = 2;
    expectDump(3, 3, 1);
    startDump(1'b0, '0, '0, 3);
    waitIdle("dump_3x3");

    $display("[TB] zero i bins: overflow beat only");
    i_bin_num = 6'd0;
    q_bin_num = 6'd2;
    applyStimulus(6'd63, 6'd0);
    clearHand();
    expectDump(0, 2, 1);
    startDump(1'b0, '0, '0, 2);
    waitIdle("dump_zero_bins");

    $display("[TB] 2x3 dump with toggling ready");
    i_bin_num = 6'd2;
    q_bin_num = 6'd3;
    applyStimulus(6'd0, 6'd1);
    applyStimulus(6'd1, 6'd2);
    applyStimulus(6'd1, 6'd2);
    applyStimulus(6'd1, 6'd2);
    clearHand();
    hand[0][1] = 1;
    hand[1][2] = 3;
    expectDump(2, 3, 0);
    ready_mode = 1;
    startDump(1'b0, '0, '0, 3);
    waitIdle("dump_toggle_ready");
    ready_mode = 0;
    clearHand();
    expectDump(2, 3, 0);
    startDump(1'b0, '0, '0, 3);
    waitIdle("dump_after_readout_clear");

    $display("[TB] in_valid during stalled dump is dropped");
    i_bin_num = 6'd2;
    q_bin_num = 6'd2;
    applyStimulus(6'd1, 6'd1);
    clearHand();
    hand[1][1] = 1;
    expectDump(2, 2, 0);
    ready_mode = 2;
    startDump(1'b0, '0, '0, 3);
    bus.in_valid   = 1'b1;
    bus.in_i_coord = 6'd1;
    bus.in_q_coord = 6'd1;
    #1;
    checkOutput("drop_in_dump", drop, 1);
    tick();
    bus.in_valid = 1'b0;
    #1;
    checkOutput("drop_one_cycle", drop, 0);
    ready_mode = 0;
    waitIdle("dump_with_drop");

    $display("[TB] sample coincident with dump_req is counted");
    clearHand();
    hand[0][1] = 1;
    expectDump(2, 2, 0);
    startDump(1'b1, 6'd0, 6'd1, 3);
    waitIdle("dump_coincident");

    $display("[TB] 65536 hits to bin (0,0)");
    i_bin_num      = 6'd1;
    q_bin_num      = 6'd1;
    bus.in_valid   = 1'b1;
    bus.in_i_coord = 6'd0;
    bus.in_q_coord = 6'd0;
    repeat (65536) tick();
    bus.in_valid = 1'b0;
    clearHand();
`ifdef HIST2D_ACC_SATURATE_EN
    hand[0][0] = 65535;
`else
    hand[0][0] = 0;
`endif
    expectDump(1, 1, 0);
    startDump(1'b0, '0, '0, 3);
    waitIdle("dump_count_limit");

    $display("[TB] reset in the middle of a dump");
    i_bin_num = 6'd2;
    q_bin_num = 6'd2;
    applyStimulus(6'd0, 6'd0);
    ready_mode = 2;
    startDump(1'b0, '0, '0, 3);
    reset = 1'b1;
    tick();
    checkOutput("reset_mid_dump_out_valid", bus.out_valid, 0);
    checkOutput("reset_mid_dump_busy", busy, 1);
    reset      = 1'b0;
    ready_mode = 0;
    waitClear("reclear_cycles");
    clearHand();
    expectDump(2, 2, 0);
    startDump(1'b0, '0, '0, 3);
    waitIdle("dump_after_reset");

    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
